// File: rtl/amba_read_channel.sv
// Slave-side AXI3-style read channel: one burst at a time, beats fetched from a
// local byte memory into a small FIFO that absorbs R-channel back-pressure.
module amba_read_channel #(
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   m2i_ARID,
  input  logic [31:0]                  m2i_ARADDR,
  input  logic [3:0]                   m2i_ARLEN,
  input  logic [2:0]                   m2i_ARSIZE,
  input  logic [1:0]                   m2i_ARBURST,
  input  logic                         m2i_ARVALID,
  output logic                         i2m_ARREADY,
  output logic [3:0]                   i2m_RID,
  output logic [7:0]                   i2m_RDATA,
  output logic [1:0]                   i2m_RRESP,
  output logic                         i2m_RLAST,
  output logic                         i2m_RVALID,
  input  logic                         m2i_RREADY,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [7:0]                   mem_wdata
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] data;
    logic [1:0] resp;
    logic       last;
  } rbeat_t;

  state_e        state_q;
  logic          arready_q;
  logic [3:0]    id_q;
  logic [AW-1:0] start_q;
  logic [3:0]    len_q;
  logic [1:0]    burst_q;
  logic [1:0]    resp_q;
  logic [3:0]    beat_q;

  logic [7:0]    mem_q  [MEM_DEPTH];
  rbeat_t        fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;

  logic          empty_c, full_c, push_c, pop_c;
  logic [AW-1:0] lmask_c, boff_c, fetch_idx_c;
  logic [1:0]    ar_resp_c;
  logic          wrap_bad_c;
  rbeat_t        push_beat_c, head_c;

  assign empty_c = (cnt_q == '0);
  assign full_c  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop_c   = !empty_c && m2i_RREADY;
  assign push_c  = (state_q == FETCH) && (!full_c || pop_c);
  assign head_c  = fifo_q[rptr_q];

  // Response decided once at acceptance; WRAP needs LEN+1 to be a power of two >= 2
  always_comb begin
    wrap_bad_c = (m2i_ARBURST == BURST_WRAP) &&
                 ((m2i_ARLEN == 4'd0) || ((m2i_ARLEN & (m2i_ARLEN + 4'd1)) != 4'd0));
    ar_resp_c  = RESP_OKAY;
    if (m2i_ARADDR >= 32'(MEM_DEPTH))
      ar_resp_c = RESP_DECERR;
    else if ((m2i_ARSIZE != 3'b000) || (m2i_ARBURST == 2'b11) || wrap_bad_c)
      ar_resp_c = RESP_SLVERR;
  end

  always_comb begin
    lmask_c     = AW'(len_q);
    boff_c      = AW'(beat_q);
    fetch_idx_c = start_q;
    case (burst_q)
      BURST_FIXED: fetch_idx_c = start_q;
      BURST_INCR:  fetch_idx_c = start_q + boff_c;
      default:     fetch_idx_c = (start_q & ~lmask_c) | ((start_q + boff_c) & lmask_c);
    endcase
    push_beat_c.id   = id_q;
    push_beat_c.data = (resp_q == RESP_OKAY) ? mem_q[fetch_idx_c] : 8'h00;
    push_beat_c.resp = resp_q;
    push_beat_c.last = (beat_q == len_q);
  end

  // Burst control FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      arready_q <= 1'b1;
      id_q      <= '0;
      start_q   <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      resp_q    <= '0;
      beat_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (m2i_ARVALID && arready_q) begin
          id_q      <= m2i_ARID;
          start_q   <= m2i_ARADDR[AW-1:0];
          len_q     <= m2i_ARLEN;
          burst_q   <= m2i_ARBURST;
          resp_q    <= ar_resp_c;
          beat_q    <= '0;
          arready_q <= 1'b0;
          state_q   <= FETCH;
        end
        FETCH: if (push_c) begin
          beat_q <= beat_q + 4'd1;
          if (beat_q == len_q) state_q <= DRAIN;
        end
        DRAIN: if (pop_c && head_c.last) begin
          arready_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          arready_q <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wptr_q] <= push_beat_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_c) wptr_q <= wptr_q + PW'(1);
      if (pop_c)  rptr_q <= rptr_q + PW'(1);
      case ({push_c, pop_c})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // R outputs follow the FIFO head and read as zero while it is empty
  assign i2m_ARREADY = arready_q;
  assign i2m_RVALID  = !empty_c;
  assign i2m_RID     = empty_c ? 4'h0 : head_c.id;
  assign i2m_RDATA   = empty_c ? 8'h00 : head_c.data;
  assign i2m_RRESP   = empty_c ? 2'b00 : head_c.resp;
  assign i2m_RLAST   = empty_c ? 1'b0 : head_c.last;

endmodule

// File: tb/tb_amba_read_channel.sv
// Directed bench for amba_read_channel: bursts, wrap/fixed sequencing,
// back-pressure, error responses, reset mid-burst and held ARVALID.
module tb_amba_read_channel;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] m2i_ARID;
  logic [31:0] m2i_ARADDR;
  logic [3:0] m2i_ARLEN;
  logic [2:0] m2i_ARSIZE;
  logic [1:0] m2i_ARBURST;
  logic       m2i_ARVALID;
  logic       i2m_ARREADY;
  logic [3:0] i2m_RID;
  logic [7:0] i2m_RDATA;
  logic [1:0] i2m_RRESP;
  logic       i2m_RLAST;
  logic       i2m_RVALID;
  logic       m2i_RREADY;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];

  amba_read_channel #(.MEM_DEPTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .m2i_ARID(m2i_ARID), .m2i_ARADDR(m2i_ARADDR), .m2i_ARLEN(m2i_ARLEN),
    .m2i_ARSIZE(m2i_ARSIZE), .m2i_ARBURST(m2i_ARBURST), .m2i_ARVALID(m2i_ARVALID),
    .i2m_ARREADY(i2m_ARREADY), .i2m_RID(i2m_RID), .i2m_RDATA(i2m_RDATA),
    .i2m_RRESP(i2m_RRESP), .i2m_RLAST(i2m_RLAST), .i2m_RVALID(i2m_RVALID),
    .m2i_RREADY(m2i_RREADY), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    m2i_ARID = id; m2i_ARADDR = addr; m2i_ARLEN = len;
    m2i_ARSIZE = size; m2i_ARBURST = burst; m2i_ARVALID = 1'b1;
    while (!i2m_ARREADY && t < 50) begin tick(); t++; end
    if (t >= 50) chk("ar_timeout", 32'd0, 32'd1);
    tick();
    m2i_ARVALID = 1'b0;
  endtask

  // Pops n beats with RREADY high, checking against exp_q
  task automatic collect(input int n, input logic [3:0] id, input logic [1:0] resp);
    m2i_RREADY = 1'b1;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      logic [7:0] e;
      while (!i2m_RVALID && t < 20) begin tick(); t++; end
      if (t >= 20) chk("r_timeout", 32'd0, 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      chk("rid",   32'(i2m_RID),   32'(id));
      chk("rdata", 32'(i2m_RDATA), 32'(e));
      chk("rresp", 32'(i2m_RRESP), 32'(resp));
      chk("rlast", 32'(i2m_RLAST), 32'(i == n - 1));
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; m2i_ARID = '0; m2i_ARADDR = '0; m2i_ARLEN = '0; m2i_ARSIZE = '0;
    m2i_ARBURST = '0; m2i_ARVALID = 1'b0; m2i_RREADY = 1'b0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    #12;
    chk("rst_arready", 32'(i2m_ARREADY), 32'd1);
    chk("rst_rvalid",  32'(i2m_RVALID),  32'd0);
    chk("rst_rout",    32'({i2m_RID, i2m_RDATA, i2m_RRESP, i2m_RLAST}), 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      mem_we = 1'b1; mem_waddr = 4'(i); mem_wdata = 8'(i + 16);
      tick();
    end
    mem_we = 1'b0;

    // INCR from 2, with first-beat latency
    m2i_RREADY = 1'b1;
    issue(4'd5, 32'd2, 4'd3, 3'd0, 2'b01);
    chk("lat_rvalid0", 32'(i2m_RVALID), 32'd0);
    chk("lat_arready", 32'(i2m_ARREADY), 32'd0);
    tick();
    chk("lat_rvalid1", 32'(i2m_RVALID), 32'd1);
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h15};
    collect(4, 4'd5, 2'b00);
    chk("incr_arready", 32'(i2m_ARREADY), 32'd1);

    issue(4'd1, 32'd6, 4'd3, 3'd0, 2'b10);
    exp_q = '{8'h16, 8'h17, 8'h14, 8'h15};
    collect(4, 4'd1, 2'b00);

    issue(4'd2, 32'd9, 4'd2, 3'd0, 2'b00);
    exp_q = '{8'h19, 8'h19, 8'h19};
    collect(3, 4'd2, 2'b00);

    // Back-pressure: FIFO fills, head stays stable
    m2i_RREADY = 1'b0;
    issue(4'd7, 32'd14, 4'd7, 3'd0, 2'b01);
    tick(); tick();
    chk("bp_data_early", 32'(i2m_RDATA), 32'h1E);
    repeat (8) tick();
    chk("bp_rvalid", 32'(i2m_RVALID), 32'd1);
    chk("bp_data",   32'(i2m_RDATA),  32'h1E);
    chk("bp_rlast",  32'(i2m_RLAST),  32'd0);
    chk("bp_fill",   32'(dut.cnt_q),  32'd4);
    exp_q = '{8'h1E, 8'h1F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    collect(8, 4'd7, 2'b00);
    chk("bp_empty", 32'(i2m_RVALID), 32'd0);

    issue(4'd3, 32'h20, 4'd1, 3'd0, 2'b01);
    exp_q = '{8'h00, 8'h00};
    collect(2, 4'd3, 2'b11);

    issue(4'd4, 32'd3, 4'd0, 3'd1, 2'b01);
    exp_q = '{8'h00};
    collect(1, 4'd4, 2'b10);

    issue(4'd6, 32'd0, 4'd2, 3'd0, 2'b10);
    exp_q = '{8'h00, 8'h00, 8'h00};
    collect(3, 4'd6, 2'b10);

    // Held ARVALID with a new ID waits for the RLAST pop
    issue(4'd3, 32'd4, 4'd2, 3'd0, 2'b01);
    m2i_ARID = 4'd9; m2i_ARADDR = 32'd1; m2i_ARLEN = 4'd0;
    m2i_ARSIZE = 3'd0; m2i_ARBURST = 2'b01; m2i_ARVALID = 1'b1;
    exp_q = '{8'h14, 8'h15, 8'h16};
    collect(3, 4'd3, 2'b00);
    chk("hold_arready", 32'(i2m_ARREADY), 32'd1);
    tick();
    m2i_ARVALID = 1'b0;
    exp_q = '{8'h11};
    collect(1, 4'd9, 2'b00);

    // Reset mid-FETCH discards everything and clears memory
    m2i_RREADY = 1'b0;
    issue(4'd2, 32'd0, 4'd7, 3'd0, 2'b01);
    tick(); tick();
    chk("pre_rst_rvalid", 32'(i2m_RVALID), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rvalid",  32'(i2m_RVALID),  32'd0);
    chk("mid_rst_arready", 32'(i2m_ARREADY), 32'd1);
    chk("mid_rst_rdata",   32'(i2m_RDATA),   32'd0);
    #3 reset = 1'b1;
    tick();
    issue(4'd6, 32'd5, 4'd1, 3'd0, 2'b01);
    exp_q = '{8'h00, 8'h00};
    collect(2, 4'd6, 2'b00);
    chk("post_rst_arready", 32'(i2m_ARREADY), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
